// File: rtl/toast_mem_arbiter_pkg.sv
// Shared arbiter types for the ToastCore unified memory port.
// Holds the state/owner enums and the word-alignment helper.
package toast_mem_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        ARB_OWNER_IF = 1'b0,
        ARB_OWNER_DM = 1'b1
    } arb_owner_t;

    localparam int ARB_MAX_LATENCY = 4;
    localparam int ARB_CNT_W       = $clog2(ARB_MAX_LATENCY);
    localparam int STARVE_CTR_W    = 4;

    // The memory port is word addressed; requester byte offsets are dropped.
    function automatic logic [31:0] arb_word_addr(input logic [31:0] byte_addr);
        return byte_addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/toast_arb_starve_ctr.sv
// Fetch-starvation counter: counts DM grants taken while IF is waiting and
// flags when IF must win the next arbitration.
module toast_arb_starve_ctr
    import toast_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    input  logic dm_gnt,
    output logic starve
);

    logic [STARVE_CTR_W-1:0] ctr_q;
    logic [STARVE_CTR_W-1:0] ctr_d;

    // Next count: an IF grant or an idle fetch side forgives all past DM wins.
    always_comb begin
        ctr_d = ctr_q;
        if (!if_req || if_gnt) begin
            ctr_d = {STARVE_CTR_W{1'b0}};
        end else if (dm_gnt) begin
            ctr_d = ctr_q + 4'd1;
        end else begin
            ctr_d = ctr_q;
        end
        starve = (ctr_q == STARVE_CTR_W'(STARVE_LIMIT));
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_q <= {STARVE_CTR_W{1'b0}};
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/toast_mem_arbiter.sv
// Single-port memory arbiter sharing one memory port between IF and DM.
// Optional fetch fairness is enabled by defining TOAST_ARB_FAIRNESS_EN.
module toast_mem_arbiter
    import toast_mem_arbiter_pkg::*;
#(
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data
);

    localparam logic [ARB_CNT_W-1:0] RD_CNT_INIT = ARB_CNT_W'(RD_LATENCY - 1);

    if (RD_LATENCY < 1 || RD_LATENCY > ARB_MAX_LATENCY) begin : g_bad_latency
        $error("toast_mem_arbiter: RD_LATENCY out of range 1..4");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("toast_mem_arbiter: STARVE_LIMIT out of range 1..15");
    end

    arb_state_t             state_q, state_d;
    arb_owner_t             owner_q, owner_d;
    logic [ARB_CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]            if_rdata_q, if_rdata_d;
    logic [31:0]            dm_rdata_q, dm_rdata_d;

    logic starve_s;
    logic rsp_valid_s;
    logic arb_ok_s;
    logic pick_if_s;
    logic pick_dm_s;

`ifdef TOAST_ARB_FAIRNESS_EN
    toast_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk    (Clk),
        .rst    (Reset),
        .if_req (if_req),
        .if_gnt (if_gnt),
        .dm_gnt (dm_gnt),
        .starve (starve_s)
    );
`else
    assign starve_s = 1'b0;
`endif

    // Arbitration, memory port drive, response routing and next-state logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        mem_addr    = 32'h0000_0000;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_be      = 4'b0000;
        mem_wr_data = 32'h0000_0000;

        rsp_valid_s = (state_q == ARB_WAIT) && (cnt_q == {ARB_CNT_W{1'b0}});
        if_rvalid   = rsp_valid_s && (owner_q == ARB_OWNER_IF);
        dm_rvalid   = rsp_valid_s && (owner_q == ARB_OWNER_DM);

        if (if_rvalid) begin
            if_rdata   = mem_rd_data;
            if_rdata_d = mem_rd_data;
        end else begin
            if_rdata   = if_rdata_q;
            if_rdata_d = if_rdata_q;
        end
        if (dm_rvalid) begin
            dm_rdata   = mem_rd_data;
            dm_rdata_d = mem_rd_data;
        end else begin
            dm_rdata   = dm_rdata_q;
            dm_rdata_d = dm_rdata_q;
        end

        // A grant may reuse the response cycle, so reads chain every RD_LATENCY.
        arb_ok_s  = !Reset && ((state_q == ARB_IDLE) || rsp_valid_s);
        pick_if_s = if_req && (!dm_req || starve_s);
        pick_dm_s = dm_req && !pick_if_s;

        case (state_q)
            ARB_IDLE: state_d = ARB_IDLE;
            ARB_WAIT: begin
                if (cnt_q != {ARB_CNT_W{1'b0}}) begin
                    state_d = ARB_WAIT;
                    cnt_d   = cnt_q - 2'd1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (arb_ok_s && pick_dm_s) begin
            dm_gnt   = 1'b1;
            mem_addr = arb_word_addr(dm_addr);
            if (dm_we) begin
                mem_wr_en   = 1'b1;
                mem_be      = dm_be;
                mem_wr_data = dm_wdata;
                state_d     = ARB_IDLE;
            end else begin
                mem_rd_en = 1'b1;
                state_d   = ARB_WAIT;
                cnt_d     = RD_CNT_INIT;
                owner_d   = ARB_OWNER_DM;
            end
        end else if (arb_ok_s && pick_if_s) begin
            if_gnt    = 1'b1;
            mem_addr  = arb_word_addr(if_addr);
            mem_rd_en = 1'b1;
            state_d   = ARB_WAIT;
            cnt_d     = RD_CNT_INIT;
            owner_d   = ARB_OWNER_IF;
        end else begin
            if_gnt = 1'b0;
            dm_gnt = 1'b0;
        end
    end

    // Arbiter state registers; reset discards any in-flight read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= ARB_OWNER_IF;
            cnt_q      <= {ARB_CNT_W{1'b0}};
            if_rdata_q <= 32'h0000_0000;
            dm_rdata_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

endmodule

// File: tb/tb_toast_mem_arbiter.sv
// Directed bench for toast_mem_arbiter with a read-data scoreboard and a
// behavioural memory that only presents valid data RD_LATENCY cycles after a strobe.
module tb_toast_mem_arbiter;

    localparam int LAT  = 3;
    localparam int SLIM = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic [31:0] mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [3:0]  mem_be;
    logic [31:0] mem_wr_data, mem_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        is_dm;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [31:0] rd_addr_l;
    int          age;

    always #5 Clk = ~Clk;

    toast_mem_arbiter #(
        .RD_LATENCY   (LAT),
        .STARVE_LIMIT (SLIM)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_be       (dm_be),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_gnt      (dm_gnt),
        .dm_rvalid   (dm_rvalid),
        .dm_rdata    (dm_rdata),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_be      (mem_be),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0000_0013;
        else return a ^ 32'hA5A5_0000;
    endfunction

    // Memory model: data is valid only in the cycle exactly LAT cycles after the strobe.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            age       <= 0;
            rd_addr_l <= 32'h0;
        end else if (mem_rd_en) begin
            age       <= 1;
            rd_addr_l <= mem_addr;
        end else if (age != 0 && age < 8) begin
            age <= age + 1;
        end
    end
    assign mem_rd_data = (age == LAT) ? mem_val(rd_addr_l) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, if_gnt, dm_gnt, mem_rd_en, mem_wr_en, if_rvalid, dm_rvalid}, {26'd0, exp});
    endtask

    task automatic neg();
        @(negedge Clk);
    endtask

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard: pop on any response, push expected data on every read grant.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (if_rvalid || dm_rvalid) begin
                n_checks++;
                assert (sb_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected_rvalid: observed rvalid with empty queue, expected none");
                end
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    chk("sb_owner", {31'd0, dm_rvalid}, {31'd0, mon_e.is_dm});
                    chk("sb_rdata", mon_e.is_dm ? dm_rdata : if_rdata, mon_e.data);
                end
            end
            if (if_gnt && mem_rd_en) sb_q.push_back({1'b0, mem_val(if_addr & 32'hFFFF_FFFC)});
            if (dm_gnt && mem_rd_en) sb_q.push_back({1'b1, mem_val(dm_addr & 32'hFFFF_FFFC)});
        end
        chk("excl_gnt", {31'd0, if_gnt & dm_gnt}, 32'd0);
        chk("excl_strobe", {31'd0, mem_rd_en & mem_wr_en}, 32'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] seq;
        logic [5:0] exp_seq;
        int         ng;

        Reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h0;
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h10; dm_wdata = 32'h0;

        // Reset: grants and strobes gated even with requests pending.
        neg();
        chk_flags("rst_flags", 6'b000000);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        nxt();
        Reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0;
        nxt();

        // Single fetch.
        if_req = 1'b1; if_addr = 32'h100;
        neg();
        chk_flags("t1_gnt", 6'b101000);
        chk("t1_addr", mem_addr, 32'h100);
        nxt();
        if_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            neg();
            chk_flags("t1_wait", (k == LAT) ? 6'b000010 : 6'b000000);
            if (k == LAT) chk("t1_rdata", if_rdata, 32'h13);
            nxt();
        end
        neg();
        chk_flags("t1_idle", 6'b000000);
        chk("t1_hold", if_rdata, 32'h13);
        nxt();

        // Simultaneous IF and DM read: DM first, IF granted in DM response cycle.
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2006;
        neg();
        chk_flags("t2_dm_gnt", 6'b011000);
        chk("t2_dm_addr", mem_addr, 32'h2004);
        nxt();
        dm_req = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            neg();
            chk_flags("t2_wait", 6'b000000);
            nxt();
        end
        neg();
        chk_flags("t2_handoff", 6'b101001);
        chk("t2_if_addr", mem_addr, 32'h300);
        chk("t2_dm_rdata", dm_rdata, 32'hA5A5_2004);
        nxt();
        if_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            neg();
            chk_flags("t2_if_wait", (k == LAT) ? 6'b000010 : 6'b000000);
            if (k == LAT) chk("t2_dm_hold", dm_rdata, 32'hA5A5_2004);
            nxt();
        end

        // Back-to-back writes.
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            dm_addr  = 32'h2000 + 32'(4 * i);
            dm_wdata = 32'hCAFE_0000 + 32'(i);
            neg();
            chk_flags("t3_wr", 6'b010100);
            chk("t3_be", {28'd0, mem_be}, {28'd0, 4'b0011});
            chk("t3_addr", mem_addr, 32'h2000 + 32'(4 * i));
            chk("t3_wdata", mem_wr_data, 32'hCAFE_0000 + 32'(i));
            nxt();
        end
        dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0;
        neg();
        chk_flags("t3_done", 6'b000000);
        nxt();

        // Fairness: continuous DM writes with IF held.
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h3000; dm_wdata = 32'h1234_5678;
        if_req = 1'b1; if_addr = 32'h400;
        seq = 6'b000000;
        ng  = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            neg();
            if (if_gnt || dm_gnt) begin
                seq[ng] = if_gnt;
                ng++;
            end
            nxt();
        end
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0;
`ifdef TOAST_ARB_FAIRNESS_EN
        exp_seq = 6'b100100;
`else
        exp_seq = 6'b000000;
`endif
        chk("t4_ngrants", 32'(ng), 32'd6);
        chk("t4_pattern", {26'd0, seq}, {26'd0, exp_seq});
        for (int k = 0; k <= LAT; k++) begin
            neg();
            chk("t4_drain_gnt", {30'd0, if_gnt, dm_gnt}, 32'd0);
            nxt();
        end
        chk("t4_sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset one cycle after a read grant discards the read.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2008;
        neg();
        chk_flags("t5_gnt", 6'b011000);
        nxt();
        Reset = 1'b1;
        sb_q.delete();
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF;
        neg();
        chk_flags("t5_rst_flags", 6'b000000);
        chk("t5_rst_be", {28'd0, mem_be}, 32'd0);
        nxt();
        Reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0;
        for (int k = 1; k <= LAT + 1; k++) begin
            neg();
            chk_flags("t5_no_rvalid", 6'b000000);
            nxt();
        end
        chk("t5_dm_rdata_rst", dm_rdata, 32'h0);
        if_req = 1'b1; if_addr = 32'h500;
        neg();
        chk_flags("t5_idle_gnt", 6'b101000);
        nxt();
        if_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            neg();
            chk_flags("t5_fetch", (k == LAT) ? 6'b000010 : 6'b000000);
            nxt();
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
